// File: rtl/cpu_run_controller_pkg.sv
// Purpose : shared state encoding and default run-control constants for the
//           CPU run controller and the benches that drive it.
// Latency : n/a (package). Backpressure: n/a.
package cpu_run_controller_pkg;

  // Run controller state encoding (3 bits, fixed values shared with benches).
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RESET_HOLD = 3'd1,
    RUN        = 3'd2,
    DONE       = 3'd3,
    TIMEOUT    = 3'd4
  } run_state_e;

  // Defaults shared with benches.
  localparam int DEF_RESET_CYCLES = 1;
  localparam int DEF_STALL_LIMIT  = 8;
  localparam int DEF_MAX_CYCLES   = 100000;

  // Bits needed to hold the value n (at least one bit).
  function automatic int cnt_bits(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pc_stall_detector.sv
// Purpose : flags program end when the fetch PC stays unchanged for
//           STALL_LIMIT consecutive enabled samples (e.g. a `j .` loop).
// Latency : stalled is asserted combinationally in the cycle whose edge would
//           complete the STALL_LIMIT-th match. Backpressure: none.
// Ports   : clk, reset (sync, active-high), enable (sample this cycle),
//           clear (forget history), pc (observed PC), stalled (1-cycle pulse).
module pc_stall_detector
  import cpu_run_controller_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                stalled
);

  localparam int SW = cnt_bits(STALL_LIMIT);
  localparam logic [SW-1:0] LIMIT    = SW'(STALL_LIMIT);
  localparam logic [SW-1:0] LIMIT_M1 = SW'(STALL_LIMIT - 1);

  logic [PC_WIDTH-1:0] r_pc_q;
  logic                r_pc_valid;
  logic [SW-1:0]       r_stall_cnt;
  logic                w_match;

  // The first enabled sample after a clear never matches (r_pc_valid=0).
  assign w_match = r_pc_valid && (pc == r_pc_q);

  // Pulse in the cycle where this edge would bring the counter to the limit,
  // so the owning FSM can leave RUN on that very edge.
  assign stalled = enable && w_match && (r_stall_cnt == LIMIT_M1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_pc_q      <= '0;
      r_pc_valid  <= 1'b0;
      r_stall_cnt <= '0;
    end else if (enable) begin
      r_pc_q     <= pc;
      r_pc_valid <= 1'b1;
      if (!w_match) begin
        r_stall_cnt <= '0;
      end else if (r_stall_cnt != LIMIT) begin
        r_stall_cnt <= r_stall_cnt + SW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Purpose : sequences a CPU core: holds it in reset for RESET_CYCLES, runs it
//           while counting cycles/retires, stops on PC stall or timeout.
// Latency : all outputs registered; state changes take effect one edge after
//           the triggering input. Backpressure: start is dropped in RESET_HOLD/RUN.
// Ports   : clk, reset (sync active-high), start (run request), pc, retire ->
//           cpu_reset, running, done, timeout, cycle_count, retire_count.
module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int PC_WIDTH     = 32,
  parameter int CNT_WIDTH    = 32,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int STALL_LIMIT  = DEF_STALL_LIMIT,
  parameter int MAX_CYCLES   = DEF_MAX_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 retire,
  output logic                 cpu_reset,
  output logic                 running,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] retire_count
);

  localparam int HW = cnt_bits(RESET_CYCLES);
  localparam logic [HW-1:0]        HOLD_LOAD = HW'(RESET_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_SAT   = '1;
  localparam logic [CNT_WIDTH-1:0] MAX_M1    = CNT_WIDTH'(MAX_CYCLES - 1);

  run_state_e          r_state;
  logic [HW-1:0]       r_hold_cnt;

  logic                w_start_ok;
  logic                w_in_run;
  logic                w_stalled;
  logic                w_cycle_hit;
  logic [CNT_WIDTH-1:0] w_cycle_next;
  logic [CNT_WIDTH-1:0] w_retire_next;

  // start is only honoured when the core is not being reset or running.
  assign w_start_ok = start &&
                      ((r_state == IDLE) || (r_state == DONE) || (r_state == TIMEOUT));
  assign w_in_run   = (r_state == RUN);

  // This RUN edge would bring cycle_count to MAX_CYCLES.
  assign w_cycle_hit   = (cycle_count == MAX_M1);
  assign w_cycle_next  = (cycle_count  == CNT_SAT) ? cycle_count  : cycle_count  + CNT_WIDTH'(1);
  assign w_retire_next = (retire_count == CNT_SAT) ? retire_count : retire_count + CNT_WIDTH'(1);

  pc_stall_detector #(
    .PC_WIDTH    (PC_WIDTH),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall (
    .clk     (clk),
    .reset   (reset),
    .enable  (w_in_run),
    .clear   (w_start_ok),
    .pc      (pc),
    .stalled (w_stalled)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_hold_cnt   <= '0;
      cpu_reset    <= 1'b1;
      running      <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      cycle_count  <= '0;
      retire_count <= '0;
    end else begin
      case (r_state)
        IDLE, DONE, TIMEOUT: begin
          // DONE/TIMEOUT keep cpu_reset low so the core stays inspectable.
          if (w_start_ok) begin
            r_state      <= RESET_HOLD;
            r_hold_cnt   <= HOLD_LOAD;
            cpu_reset    <= 1'b1;
            running      <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            cycle_count  <= '0;
            retire_count <= '0;
          end
        end

        RESET_HOLD: begin
          r_hold_cnt <= r_hold_cnt - HW'(1);
          if (r_hold_cnt == HW'(1)) begin
            r_state   <= RUN;
            cpu_reset <= 1'b0;
            running   <= 1'b1;
          end
        end

        RUN: begin
          cycle_count <= w_cycle_next;
          if (retire) begin
            retire_count <= w_retire_next;
          end
          // Stall takes priority over a timeout landing on the same edge.
          if (w_stalled) begin
            r_state <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (w_cycle_hit) begin
            r_state <= TIMEOUT;
            running <= 1'b0;
            timeout <= 1'b1;
          end
        end

        default: begin
          r_state   <= IDLE;
          cpu_reset <= 1'b1;
          running   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Purpose : self-checking bench for cpu_run_controller against a queue-based
//           behavioural model; every output is compared after every edge.
// Latency/backpressure: n/a (bench).
module tb_cpu_run_controller;

  localparam int RC = 4;   // reset hold cycles
  localparam int SL = 6;   // stall limit
  localparam int MC = 30;  // max RUN cycles

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] pc;
  logic        retire;
  logic        cpu_reset;
  logic        running;
  logic        done;
  logic        timeout;
  logic [31:0] cycle_count;
  logic [31:0] retire_count;

  always #5 clk = ~clk;

  cpu_run_controller #(
    .PC_WIDTH     (32),
    .CNT_WIDTH    (32),
    .RESET_CYCLES (RC),
    .STALL_LIMIT  (SL),
    .MAX_CYCLES   (MC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pc           (pc),
    .retire       (retire),
    .cpu_reset    (cpu_reset),
    .running      (running),
    .done         (done),
    .timeout      (timeout),
    .cycle_count  (cycle_count),
    .retire_count (retire_count)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: hold cycles left, run/ended flags, counts, and the
  // PC samples of the current run. A run ends by stall when the newest
  // SL+1 samples are all equal.
  int          m_hold = 0;
  bit          m_run  = 0;
  bit          m_done = 0;
  bit          m_to   = 0;
  int          m_cyc  = 0;
  int          m_ret  = 0;
  logic [31:0] hist[$];

  task automatic model_edge(input bit rst, input bit st, input logic [31:0] p, input bit ret);
    bit stall;
    if (rst) begin
      m_hold = 0; m_run = 0; m_done = 0; m_to = 0; m_cyc = 0; m_ret = 0;
      hist.delete();
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_run = 1;
    end else if (m_run) begin
      m_cyc++;
      if (ret) m_ret++;
      hist.push_back(p);
      stall = 0;
      if (hist.size() >= SL + 1) begin
        stall = 1;
        for (int k = 1; k <= SL; k++)
          if (hist[hist.size() - 1 - k] != p) stall = 0;
      end
      if (stall) begin
        m_done = 1; m_run = 0;
      end else if (m_cyc == MC) begin
        m_to = 1; m_run = 0;
      end
    end else if (st) begin
      m_hold = RC; m_done = 0; m_to = 0; m_cyc = 0; m_ret = 0;
      hist.delete();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
  endtask

  task automatic check_all();
    chk("cpu_reset",    {31'd0, cpu_reset}, {31'd0, !(m_run || m_done || m_to)});
    chk("running",      {31'd0, running},   {31'd0, m_run});
    chk("done",         {31'd0, done},      {31'd0, m_done});
    chk("timeout",      {31'd0, timeout},   {31'd0, m_to});
    chk("cycle_count",  cycle_count,        m_cyc);
    chk("retire_count", retire_count,       m_ret);
  endtask

  // Drive inputs at the falling edge, let the rising edge act, compare at the
  // next falling edge.
  task automatic cyc(input bit rst, input bit st, input logic [31:0] p, input bit ret);
    reset = rst; start = st; pc = p; retire = ret;
    @(posedge clk);
    model_edge(rst, st, p, ret);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [31:0] p;
    logic [31:0] c;
    reset = 1'b1; start = 1'b0; pc = '0; retire = 1'b0;
    @(negedge clk);

    // Reset state, then idle with noise on the core inputs.
    repeat (2) cyc(1, 0, 32'd0, 0);
    repeat (3) cyc(0, 0, $urandom, 1'($urandom_range(0, 1)));

    // Run ending in a PC stall; extra starts during RESET_HOLD are ignored.
    cyc(0, 1, 32'h0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, $urandom, 1'($urandom_range(0, 1)));
    p = 32'h1000;
    for (int i = 0; i < 10; i++) begin
      p += 32'(4 * (1 + $urandom_range(0, 3)));
      cyc(0, 1'($urandom_range(0, 1)), p, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 20 && !m_done; i++) cyc(0, 0, p, 1'($urandom_range(0, 1)));
    chk("stall_done", {31'd0, done}, 32'd1);
    // Frozen counters while in DONE.
    repeat (4) cyc(0, 0, $urandom, 1'($urandom_range(0, 1)));

    // Timeout run: PC always advancing, retire every other cycle.
    cyc(0, 1, 32'h0, 0);
    p = 32'h2000;
    for (int i = 0; i < 60 && !m_to; i++) begin
      p += 32'd4;
      cyc(0, 1'($urandom_range(0, 1)), p, 1'(i % 2));
    end
    chk("to_flag",   {31'd0, timeout}, 32'd1);
    chk("to_cycles", cycle_count, 32'(MC));
    repeat (3) cyc(0, 0, $urandom, 1'($urandom_range(0, 1)));

    // Stall completing on the same edge as the timeout: done wins.
    cyc(0, 1, 32'h0, 0);
    c = 32'hDEAD_0000;
    for (int i = 0; i < 60 && !(m_done || m_to); i++) begin
      if (m_run && (m_cyc + 1 >= MC - SL)) p = c;
      else p = 32'h100 + 32'(i * 4);
      cyc(0, 0, p, 1'($urandom_range(0, 1)));
    end
    chk("tie_done",    {31'd0, done},    32'd1);
    chk("tie_timeout", {31'd0, timeout}, 32'd0);

    // Reset in the middle of RUN, then rerun to a stall and restart from DONE.
    cyc(0, 1, 32'h0, 0);
    p = 32'h3000;
    for (int i = 0; i < 40 && m_cyc < 5; i++) begin
      p += 32'd4;
      cyc(0, 0, p, 1'($urandom_range(0, 1)));
    end
    cyc(1, 0, p, 1);
    chk("midrun_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    cyc(0, 1, 32'h0, 0);
    for (int i = 0; i < 40 && !m_done; i++) cyc(0, 0, 32'h44, 1'($urandom_range(0, 1)));
    cyc(0, 1, 32'h0, 0);
    chk("restart_clears_done", {31'd0, done}, 32'd0);
    repeat (8) cyc(0, 0, $urandom, 1'($urandom_range(0, 1)));

    // Random soak: sparse resets and starts, PC from a two-value set.
    for (int i = 0; i < 800; i++) begin
      cyc(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) == 0),
          32'($urandom_range(0, 1) * 4), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
